// File: rtl/fft_top.sv
// rtl/fft_top.sv - streaming 1024-point radix-2 SDF DIF FFT, bit-reversed output
module fft_top #(
  parameter int N     = 1024,
  parameter int LOG2N = 10,
  parameter int W     = 16,
  parameter int TW    = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [W-1:0] xb_re,
  input  logic [W-1:0] xb_im,
  output logic [W-1:0] Xb_re,
  output logic [W-1:0] Xb_im
);

  localparam real PI   = 3.14159265358979323846;
  localparam int  FRAC = TW - 2;

  // Round-half-away-from-zero to the twiddle fixed-point grid; only used on constants.
  function automatic logic signed [TW-1:0] q14(input real v);
    real scaled;
    scaled = v * real'(1 << FRAC);
    if (scaled >= 0.0) return TW'($rtoi(scaled + 0.5));
    else               return TW'(-$rtoi(0.5 - scaled));
  endfunction

  // Clamp a wide product sum to the signed W-bit range.
  function automatic logic signed [W-1:0] sat(input logic signed [W+TW:0] v);
    if (v[W+TW:W-1] == {(TW+2){v[W+TW]}}) return v[W-1:0];
    else return v[W+TW] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  endfunction

  // Twiddle ROM: W^k = tw_c[k] + j*tw_s[k], k = 0..N/2-1, fixed at elaboration.
  logic signed [TW-1:0] tw_c [N/2];
  logic signed [TW-1:0] tw_s [N/2];
  for (genvar k = 0; k < N/2; k++) begin : g_rom
    assign tw_c[k] = q14($cos(2.0 * PI * real'(k) / real'(N)));
    assign tw_s[k] = q14(-$sin(2.0 * PI * real'(k) / real'(N)));
  end

  logic [LOG2N-1:0]    cnt_q;
  logic signed [W-1:0] in_re_q, in_im_q;
  // st_*[s] feeds stage s; st_*[LOG2N] is the final stage register.
  logic signed [W-1:0] st_re [LOG2N+1];
  logic signed [W-1:0] st_im [LOG2N+1];

  // Sample counter and input register advance together on enabled edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      in_re_q <= '0;
      in_im_q <= '0;
    end else if (enable) begin
      cnt_q   <= cnt_q + LOG2N'(1);
      in_re_q <= xb_re;
      in_im_q <= xb_im;
    end
  end

  assign st_re[0] = in_re_q;
  assign st_im[0] = in_im_q;

  for (genvar s = 0; s < LOG2N; s++) begin : g_stage
    localparam int D   = (N / 2) >> s;
    localparam int TGW = LOG2N - s;
    // Pipeline distance from the counter to this stage's input, so the tag
    // equals the frame index of the sample arriving at this stage.
    localparam int OFF = (1 + N - (N >> s) + s) % N;
    localparam int SRW = 2 * W * D;

    logic [TGW-1:0]        tag;
    logic                  bfly;
    logic [LOG2N-2:0]      k;
    logic signed [W-1:0]   a_re, a_im, b_re, b_im;
    logic signed [W-1:0]   dn_re, dn_im, lw_re, lw_im;
    logic signed [W+TW-1:0] p_rc, p_is, p_rs, p_ic;
    logic signed [W+TW:0]  acc_re, acc_im;
    logic [2*W-1:0]        push;
    logic [SRW-1:0]        dl_q;
    logic signed [W-1:0]   out_re_d, out_im_d, out_re_q, out_im_q;

    assign tag  = TGW'(cnt_q - LOG2N'(OFF));
    assign bfly = tag[TGW-1];
    if (D > 1) begin : g_k
      assign k = (LOG2N-1)'(tag[TGW-2:0]) << s;
    end else begin : g_k0
      assign k = '0;
    end

    assign {a_re, a_im} = dl_q[SRW-1 -: 2*W];
    assign b_re = st_re[s];
    assign b_im = st_im[s];

    // Butterfly with twiddle on the difference path, then fill/butterfly phase select.
    always_comb begin
      dn_re  = W'(($signed({a_re[W-1], a_re}) - $signed({b_re[W-1], b_re})) >>> 1);
      dn_im  = W'(($signed({a_im[W-1], a_im}) - $signed({b_im[W-1], b_im})) >>> 1);
      p_rc   = (W+TW)'(dn_re) * (W+TW)'(tw_c[k]);
      p_is   = (W+TW)'(dn_im) * (W+TW)'(tw_s[k]);
      p_rs   = (W+TW)'(dn_re) * (W+TW)'(tw_s[k]);
      p_ic   = (W+TW)'(dn_im) * (W+TW)'(tw_c[k]);
      acc_re = {p_rc[W+TW-1], p_rc} - {p_is[W+TW-1], p_is} + (W+TW+1)'(1 << (FRAC - 1));
      acc_im = {p_rs[W+TW-1], p_rs} + {p_ic[W+TW-1], p_ic} + (W+TW+1)'(1 << (FRAC - 1));
      lw_re  = sat(acc_re >>> FRAC);
      lw_im  = sat(acc_im >>> FRAC);
      if (bfly) begin
        out_re_d = W'(($signed({a_re[W-1], a_re}) + $signed({b_re[W-1], b_re})) >>> 1);
        out_im_d = W'(($signed({a_im[W-1], a_im}) + $signed({b_im[W-1], b_im})) >>> 1);
        push     = {lw_re, lw_im};
      end else begin
        out_re_d = a_re;
        out_im_d = a_im;
        push     = {b_re, b_im};
      end
    end

    // Delay line shifts one slot per enabled cycle; stage output is registered.
    always_ff @(posedge clk) begin
      if (rst) begin
        dl_q     <= '0;
        out_re_q <= '0;
        out_im_q <= '0;
      end else if (enable) begin
        dl_q     <= SRW'({dl_q, push});
        out_re_q <= out_re_d;
        out_im_q <= out_im_d;
      end
    end

    assign st_re[s+1] = out_re_q;
    assign st_im[s+1] = out_im_q;
  end

  assign Xb_re = st_re[LOG2N];
  assign Xb_im = st_im[LOG2N];

endmodule

// File: tb/tb_fft_top.sv
// tb/tb_fft_top.sv - scoreboard bench for fft_top
module tb_fft_top;
  logic        clk = 1'b0;
  logic        rst, enable;
  logic [15:0] xb_re, xb_im, Xb_re, Xb_im;

  fft_top dut (
    .clk(clk), .rst(rst), .enable(enable),
    .xb_re(xb_re), .xb_im(xb_im), .Xb_re(Xb_re), .Xb_im(Xb_im)
  );

  always #5 clk = ~clk;

  localparam real PI = 3.14159265358979323846;
  localparam int DC = 0, IMP = 1, TONE = 2, FULL = 3;

  typedef struct {
    int    re;
    int    im;
    int    tol;
    int    due;
    string tag;
  } exp_t;

  exp_t sb[$];
  exp_t hold;
  int   ecnt   = 0;
  int   checks = 0;
  int   passes = 0;

  function automatic int bitrev(input int j);
    int r;
    r = 0;
    for (int i = 0; i < 10; i++) if (j[i]) r = r | (1 << (9 - i));
    return r;
  endfunction

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  task automatic compare(input exp_t e);
    int ore, oim;
    ore = int'($signed(Xb_re));
    oim = int'($signed(Xb_im));
    checks++;
    if (e.tol == 0) begin
      assert ({Xb_re, Xb_im} === {e.re[15:0], e.im[15:0]}) passes++;
      else $error("FAIL %s: got (%0d,%0d) expected (%0d,%0d)", e.tag, ore, oim, e.re, e.im);
    end else begin
      assert (((ore - e.re <= e.tol) && (e.re - ore <= e.tol) &&
               (oim - e.im <= e.tol) && (e.im - oim <= e.tol)) === 1'b1) passes++;
      else $error("FAIL %s: got (%0d,%0d) expected (%0d,%0d) +/-%0d",
                  e.tag, ore, oim, e.re, e.im, e.tol);
    end
  endtask

  // One clock: drive, clock, sample 1 time unit later, check due result or held value.
  task automatic step(input logic en, input logic r, input int re, input int im);
    enable = en;
    rst    = r;
    xb_re  = 16'(re);
    xb_im  = 16'(im);
    @(posedge clk);
    if (r) begin
      sb.delete();
      hold = '{0, 0, 0, 0, "reset"};
    end else if (en) begin
      ecnt++;
    end
    #1;
    if (sb.size() > 0 && sb[0].due == ecnt) begin
      hold = sb.pop_front();
      compare(hold);
    end else begin
      compare(hold);
    end
  endtask

  task automatic maybe_stall(input logic stall);
    if (stall && (ecnt % 100 == 50))
      for (int i = 0; i < 3; i++)
        step(1'b0, 1'b0, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
  endtask

  task automatic run_frame(input int kind, input logic stall, input string name);
    for (int n = 0; n < 1024; n++) begin
      int   re, bin;
      exp_t e;
      bin = bitrev(n);
      case (kind)
        DC:      re = 1;
        IMP:     re = (n == 0) ? 1024 : 0;
        TONE:    re = rnd(16384.0 * $cos(2.0 * PI * 10.0 * real'(n) / 1024.0));
        default: re = -32768;
      endcase
      e.re  = 0;
      e.im  = 0;
      e.tol = 0;
      case (kind)
        DC:      if (bin == 0) e.re = 1;
        FULL:    if (bin == 0) e.re = -32768;
        IMP:     e.re = 1;
        default: begin
          e.tol = 4;
          if (bin == 10 || bin == 1014) e.re = 8192;
        end
      endcase
      maybe_stall(stall);
      step(1'b1, 1'b0, re, 0);
      e.due = ecnt + 1033;
      e.tag = $sformatf("%s slot %0d", name, n);
      sb.push_back(e);
    end
  endtask

  task automatic drain(input logic stall);
    int guard;
    guard = 0;
    while (sb.size() > 0 && guard < 4000) begin
      maybe_stall(stall);
      step(1'b1, 1'b0, 0, 0);
      guard++;
    end
    checks++;
    assert (sb.size() === 0) passes++;
    else $error("FAIL drain: %0d results still queued, expected 0", sb.size());
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    xb_re  = '0;
    xb_im  = '0;
    hold   = '{0, 0, 0, 0, "reset"};

    step(1'b0, 1'b1, 0, 0);
    step(1'b1, 1'b1, 0, 0);
    run_frame(DC, 1'b0, "dc");
    drain(1'b0);

    step(1'b1, 1'b1, 0, 0);
    run_frame(TONE, 1'b0, "tone");
    drain(1'b0);

    step(1'b1, 1'b1, 0, 0);
    run_frame(FULL, 1'b0, "full");
    drain(1'b0);

    step(1'b1, 1'b1, 0, 0);
    run_frame(DC, 1'b1, "stall");
    drain(1'b1);

    step(1'b1, 1'b1, 0, 0);
    run_frame(IMP, 1'b0, "impulse");
    for (int n = 0; n < 500; n++) step(1'b1, 1'b0, 1, 0);
    step(1'b1, 1'b1, 0, 0);
    run_frame(DC, 1'b0, "restart");
    drain(1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
